// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage data memory with MIPS sub-word access, registered loads and a post-reset clear sequence.
// Optional per-request trace dump when DATA_MEM_TRACE_EN is defined.
module data_mem_unit #(
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] in_pos,
  input  logic [31:0]       in_data,
  input  logic              Ctrl_MemWr,
  input  logic              Ctrl_MemRd,
  input  logic [1:0]        Ctrl_MemSize,
  input  logic              Ctrl_MemSign,
  output logic [31:0]       Mem_out,
  output logic              Mem_valid,
  output logic              Mem_fault,
  output logic              Mem_busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic valid_q, valid_d, fault_q, fault_d, busy_q, busy_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx, w_idx;
  logic [1:0] off;
  logic ready, req, ill, we, last, unused_pos;
  logic [31:0] word, w_word, mask, rep, ld;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  always_comb begin
    idx = in_pos[AW+1:2];
    off = in_pos[1:0];
    unused_pos = ^in_pos;
    ready = state_q == READY;
    last = clr_idx_q == AW'(DEPTH - 1);
    req = ready & (Ctrl_MemRd | Ctrl_MemWr);
    ill = (Ctrl_MemSize == 2'b11) | (Ctrl_MemSize == 2'b01 & off[0]) | (Ctrl_MemSize == 2'b10 & off != 2'b00);
    word = mem[idx];
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    ld = Ctrl_MemSize == 2'b10 ? word :
         Ctrl_MemSize == 2'b01 ? {{16{Ctrl_MemSign & lane_h[15]}}, lane_h} :
                                 {{24{Ctrl_MemSign & lane_b[7]}}, lane_b};
    mask = Ctrl_MemSize == 2'b10 ? 32'hFFFF_FFFF :
           Ctrl_MemSize == 2'b01 ? (off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                                   32'h0000_00FF << {off, 3'b000};
    rep = Ctrl_MemSize == 2'b10 ? in_data :
          Ctrl_MemSize == 2'b01 ? {2{in_data[15:0]}} : {4{in_data[7:0]}};
    // the single write port is shared by the clear sequence and stores
    we = ready ? Ctrl_MemWr & ~ill : 1'b1;
    w_idx = ready ? idx : clr_idx_q;
    w_word = ready ? (word & ~mask) | (rep & mask) : 32'h0;
    state_d = (!ready && last) ? READY : state_q;
    clr_idx_d = ready ? clr_idx_q : clr_idx_q + 1'b1;
    busy_d = !ready && !last;
    valid_d = req & Ctrl_MemRd & ~ill;
    fault_d = req & ill;
    mem_out_d = valid_d ? ld : mem_out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
      mem_out_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      mem_out_q <= mem_out_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      busy_q <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && we) mem[w_idx] <= w_word;
  end
`ifdef DATA_MEM_TRACE_EN
  always @(posedge clk) begin
    if (!rst && req) begin
      for (int r = 0; r < 4; r++) begin
        $write("M[%02d-%02d]=", r * 8, r * 8 + 7);
        for (int c = 0; c < 8; c++) $write("%8X%s", mem[(r * 8 + c) % DEPTH], c == 7 ? "\n" : ", ");
      end
      $display("in_pos=%h in_data=%h Wr=%b Rd=%b Size=%b", in_pos, in_data, Ctrl_MemWr, Ctrl_MemRd, Ctrl_MemSize);
      if (ill) $display("FAULT");
    end
  end
`else
`endif
  assign Mem_out = mem_out_q;
  assign Mem_valid = valid_q;
  assign Mem_fault = fault_q;
  assign Mem_busy = busy_q;
endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Parametrised data memory for the Pipeline MEM stage.
- Supports MIPS sub-word loads and stores (lb/lbu/lh/lhu/lw, sb/sh/sw) with byte lanes and sign/zero extension.
- Read port is registered; misaligned accesses are flagged.
- After reset, a hardware clear sequence zeroes the array; the stage stalls on Mem_busy until it completes.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two, >= 2.
- ADDR_W, 32, width of in_pos.
- Derived, not overridable: AW = clog2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_pos  input  ADDR_W  byte address.
- in_data  input  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- Ctrl_MemWr  input  1  store request.
- Ctrl_MemRd  input  1  load request.
- Ctrl_MemSize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- Ctrl_MemSign  input  1  1 = sign-extend loads, 0 = zero-extend.
- Mem_out  output  32  load result.
- Mem_valid  output  1  one-cycle pulse; Mem_out is updated this cycle.
- Mem_fault  output  1  one-cycle pulse on a rejected access.
- Mem_busy  output  1  clear sequence in progress; requests are ignored.

Behaviour:
- Reset, on a posedge with rst=1:
  - state <= CLEAR, clr_idx <= 0.
  - Mem_out <= 0, Mem_valid <= 0, Mem_fault <= 0, Mem_busy <= 1.
  - rst has priority over everything. Asserting rst mid-CLEAR restarts from index 0.
- FSM, two states:
  - CLEAR: each cycle writes word[clr_idx] <= 0 and increments clr_idx. Takes exactly DEPTH cycles. On the cycle that writes index DEPTH-1, next state is READY and Mem_busy <= 0.
  - READY: stays until rst.
- While busy, Ctrl_MemRd and Ctrl_MemWr are ignored: no array write, no Mem_valid, no Mem_fault.
- Addressing:
  - word index = in_pos[AW+1:2]; byte offset = in_pos[1:0].
  - Bits above AW+1 are ignored, so the address wraps modulo DEPTH*4.
  - Little-endian lanes: offset 0 maps to bits [7:0].
- Request legality (READY, with Rd or Wr asserted):
  - Size 11 is illegal.
  - Half with in_pos[0]=1 is illegal.
  - Word with in_pos[1:0]!=0 is illegal.
  - An illegal request causes no array write, Mem_fault=1 and Mem_valid=0 on the next cycle, and Mem_out holds its value.
- Store:
  - Committed at the request edge.
  - Only the addressed lanes change: byte writes lane off; half writes lanes off and off+1; word writes all four.
  - Other lanes are preserved.
- Load:
  - Latency 1: request at edge N; Mem_out and Mem_valid=1 are registered at edge N, visible in cycle N+1.
  - Byte result is the lane at off; half result is lanes off+1:off. Either is extended per Ctrl_MemSign.
  - Word ignores Ctrl_MemSign.
- Rd and Wr in the same cycle to the same word:
  - The read returns the old contents (read-before-write).
  - The write is committed.
- Store at N followed by a load at N+1 to the same address: the load returns the new data.
- No request: Mem_out holds its last value; Mem_valid=0, Mem_fault=0.
- Mem_valid and Mem_fault are never both 1.

Optional Feature:
- Macro: DATA_MEM_TRACE_EN.
- Defined: on every posedge in READY with Rd or Wr asserted, $display the following:
  - words 0..31, formatted 8 per line as "M[00-07]=%8X, ...".
  - in_pos, in_data, Ctrl_MemWr, Ctrl_MemRd, Ctrl_MemSize.
  - a "FAULT" line if the request is illegal.
- Not defined: no $display statements are compiled; behaviour is otherwise identical.

Test Plan:
- Clear sequence: pulse rst for 1 cycle with DEPTH=16 -> Mem_busy=1 for exactly 16 cycles, then 0. lw of every address returns 0x00000000. A request during busy gives no Mem_valid and no write.
- Sub-word stores: sw 0x11223344 @0x8; sb 0xAA @0x9; sh 0xBEEF @0xA; lw @0x8 -> 0xBEEFAA44 with Mem_valid exactly 1 cycle after the request.
- Loads with extension: after sw 0x80FF7F01 @0x4:
  - lb @0x6 -> 0xFFFFFFFF; lbu @0x6 -> 0x000000FF.
  - lh @0x6 -> 0xFFFF80FF; lhu @0x6 -> 0x000080FF.
  - lb @0x4 -> 0x00000001.
- Faults: sh @0x3, sw @0x2, size 11 @0x0 -> Mem_fault=1 one cycle later, Mem_valid=0, memory unchanged (lw @0x0 returns the prior value).
- Hazards: Rd+Wr same cycle sw 0x55 @0xC over 0x77 -> Mem_out=0x77; next lw @0xC -> 0x55. With DEPTH=16, sw 0x99 @0x40 then lw @0x0 -> 0x99 (wrap).
- Reset mid-operation: assert rst during CLEAR at idx 7 -> CLEAR restarts, busy lasts a further DEPTH cycles. Assert rst in the cycle after an lw -> Mem_out=0, Mem_valid=0.
